// File: rtl/dsp_pipe_reg.sv
// Variable-depth pipeline register with runtime-selectable output tap, valid tracking and sync flush.
// Optional parity protection of the stored data is enabled with `define DSP_PIPE_PARITY_EN.
module dsp_pipe_reg #(
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 4,
  parameter int LW         = $clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SRST,
  input  logic                  CE,
  input  logic [LW-1:0]         LAT,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  D_VLD,
`ifdef DSP_PIPE_PARITY_EN
  input  logic                  PINJ,
`endif
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  Q_VLD,
  output logic                  PERR
);

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]      vld_q;
  logic [DEPTH-1:0]      vld_d;
  logic [LW-1:0]         lat_eff;

  // Out-of-range latencies behave as the deepest tap.
  always_comb begin
    lat_eff = (LAT > LW'(DEPTH)) ? LW'(DEPTH) : LAT;
  end

  // NOTE: every output of a combinational block is given a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (SRST) begin
      for (int i = 0; i < DEPTH; i++) data_d[i] = '0;
      vld_d = '0;
    end else if (CE) begin
      data_d[0] = D;
      vld_d[0]  = D_VLD;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
    end
  end

  // NOTE: the stage array is reset in full, not just the valid bits, because Q must read 0 from any tap after reset.
  // NOTE: sequential state uses non-blocking assignment so every stage samples its neighbour's pre-edge value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      vld_q <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  // Tap 0 is a combinational bypass of the input.
  always_comb begin
    Q     = D;
    Q_VLD = D_VLD;
    for (int i = 0; i < DEPTH; i++) begin
      if (lat_eff == LW'(i + 1)) begin
        Q     = data_q[i];
        Q_VLD = vld_q[i];
      end
    end
  end

`ifdef DSP_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic [DEPTH-1:0] par_d;
  logic             tap_par;
  logic             perr_q;
  logic             perr_d;

  always_comb begin
    tap_par = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (lat_eff == LW'(i + 1)) tap_par = par_q[i];
    end
  end

  // The error flag is sticky and checked every edge, whether or not the chain advances.
  always_comb begin
    par_d  = par_q;
    perr_d = perr_q;
    if (SRST) begin
      par_d  = '0;
      perr_d = 1'b0;
    end else begin
      if (CE) begin
        par_d[0] = (^D) ^ PINJ;
        for (int i = 1; i < DEPTH; i++) par_d[i] = par_q[i-1];
      end
      if ((lat_eff != '0) && Q_VLD && ((^Q) != tap_par)) perr_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign PERR = perr_q;
`else
  assign PERR = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_pipe_reg.sv
// Scoreboard bench for dsp_pipe_reg: a sample-history model predicts each valid output and the PERR flag.
module tb_dsp_pipe_reg;
  localparam int DW    = 18;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          CLK = 1'b0;
  logic          RST, SRST, CE, D_VLD, pinj;
  logic [LW-1:0] LAT;
  logic [DW-1:0] D, Q;
  logic          Q_VLD, PERR;

  dsp_pipe_reg #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .SRST(SRST), .CE(CE), .LAT(LAT), .D(D), .D_VLD(D_VLD),
`ifdef DSP_PIPE_PARITY_EN
    .PINJ(pinj),
`endif
    .Q(Q), .Q_VLD(Q_VLD), .PERR(PERR)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic vld; logic [DW-1:0] data; logic par; } ent_t;
  typedef struct { int cyc; logic [DW-1:0] data; } exp_t;

  ent_t hist [DEPTH];   // hist[k-1] = sample accepted k enabled edges ago
  exp_t sb [$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic exp_perr = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int eff_lat();
    return (int'(LAT) > DEPTH) ? DEPTH : int'(LAT);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) hist[i] = '{vld: 1'b0, data: '0, par: 1'b0};
    exp_perr = 1'b0;
  endtask

  // Advance the model over one rising edge using the inputs present at that edge.
  task automatic model_edge();
    int   k;
    logic bad;
    k   = eff_lat();
    bad = (k >= 1) && hist[k-1].vld && ((^hist[k-1].data) != hist[k-1].par);
    if (RST || SRST) begin
      model_clear();
    end else begin
      if (CE) begin
        for (int i = DEPTH - 1; i >= 1; i--) hist[i] = hist[i-1];
        hist[0] = '{vld: D_VLD, data: D, par: (^D) ^ pinj};
      end
`ifdef DSP_PIPE_PARITY_EN
      if (bad) exp_perr = 1'b1;
`else
      if (bad) exp_perr = 1'b0;
`endif
    end
  endtask

  task automatic tick(input logic rst, input logic srst, input logic ce, input int lat,
                      input logic [DW-1:0] d, input logic dvld, input logic pj);
    ent_t e;
    int   k;
    @(posedge CLK);
    #1;
    model_edge();
    cyc++;
    RST = rst; SRST = srst; CE = ce; LAT = LW'(lat); D = d; D_VLD = dvld; pinj = pj;
    if (rst) model_clear();
    #1;
    check("perr", PERR, exp_perr);
    k = eff_lat();
    if (k == 0) e = '{vld: dvld, data: d, par: 1'b0};
    else        e = hist[k-1];
    if (e.vld) sb.push_back('{cyc: cyc, data: e.data});
  endtask

  // Monitor: consumes one expectation per valid output seen on the falling edge.
  always @(negedge CLK) begin
    exp_t e;
    if (Q_VLD === 1'b1) begin
      if (sb.size() == 0) begin
        check("q_vld_unexpected", Q_VLD, 1'b0);
      end else begin
        e = sb.pop_front();
        check("q_cycle", cyc, e.cyc);
        check("q_data", Q, e.data);
      end
    end
  end

  initial begin
    RST = 1'b1; SRST = 1'b0; CE = 1'b0; LAT = LW'(3); D = '0; D_VLD = 1'b0; pinj = 1'b0;
    model_clear();
    #2;
    check("reset_q", Q, '0);
    check("reset_q_vld", Q_VLD, 1'b0);
    check("reset_perr", PERR, 1'b0);
    tick(1, 0, 0, 3, '0, 0, 0);
    tick(1, 0, 0, 3, '0, 0, 0);

    // Stream at LAT=3, reset mid-stream, then restart with leading invalid samples.
    for (int i = 0; i < 6; i++) tick(0, 0, 1, 3, DW'(i + 1), 1, 0);
    tick(1, 0, 1, 3, DW'('h2AAAA), 1, 0);
    check("midrst_q", Q, '0);
    check("midrst_q_vld", Q_VLD, 1'b0);
    for (int i = 0; i < 8; i++) tick(0, 0, 1, 3, DW'(i + 'h100), (i >= 2), 0);

    // Latency sweep with incrementing data.
    for (int l = 0; l <= DEPTH; l++) begin
      for (int i = 0; i < 8; i++) tick(0, 0, 1, l, DW'(l * 16 + i + 1), 1, 0);
      if (l == 0) check("bypass_q", Q, DW'(8));
    end

    // CE stall at LAT=2.
    tick(0, 0, 1, 2, DW'('h3FFFF), 1, 0);
    tick(0, 0, 1, 2, '0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 2, DW'('h00005), 1, 0);
    check("stall_q", Q, DW'('h3FFFF));
    tick(0, 0, 1, 2, DW'('h00005), 1, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 2, '0, 0, 0);

    // Flush has priority over CE; the flushed sample never appears.
    for (int i = 0; i < 5; i++) tick(0, 0, 1, 4, DW'('h200 + i), 1, 0);
    tick(0, 1, 1, 4, DW'('h12345), 1, 0);
    for (int l = 1; l <= 7; l++) begin
      tick(0, 0, 0, l, '0, 0, 0);
      check("flush_q_vld", Q_VLD, 1'b0);
    end

    // Clamp and live LAT change.
    for (int i = 0; i < 8; i++) tick(0, 0, 1, 7, DW'('h300 + i), 1, 0);
    check("clamp_q", Q, DW'('h303));
    tick(0, 0, 0, 1, '0, 0, 0);
    check("latchg_q", Q, DW'('h307));
    tick(0, 0, 0, 4, '0, 0, 0);
    check("latchg_back_q", Q, DW'('h304));
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 1, DW'('h400 + i), 1, 0);

    // Parity inject at LAT=2, then flush clears the flag.
    tick(0, 0, 1, 2, DW'('h0000F), 1, 1);
    for (int i = 0; i < 5; i++) tick(0, 0, 1, 2, DW'('h500 + i), 1, 0);
    tick(0, 1, 1, 2, '0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 2, DW'('h600 + i), 1, 0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
           DW'($urandom), $urandom_range(0, 1) == 1, ($urandom_range(0, 63) == 0));
    end

    @(negedge CLK);
    #1;
    check("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dsp_pipe_reg.md
# dsp_pipe_reg

Parametrised pipeline register for the DSP48A1 datapath. It generalises the single optional input/output register into a shift chain of up to DEPTH stages, with a runtime-selectable output tap, a valid bit tracked alongside the data, and a synchronous flush. It sits on the A/B/C/D/M/P operand and result paths, where latency must be matched to other paths without re-synthesis.

## Interface
Parameters:
- DATA_WIDTH, 18, width of the data bus (1..64).
- DEPTH, 4, number of physical register stages (1..8).
- LW, $clog2(DEPTH+1), width of LAT; derived, do not override.

Ports:
- CLK  input  1  clock; all stages update on the rising edge.
- RST  input  1  reset, asynchronous, active-high; clears all stages, valid bits and PERR.
- SRST  input  1  synchronous flush, active-high; same effect as RST at the next rising edge.
- CE  input  1  clock enable for the whole chain.
- LAT  input  LW  selected latency, 0..DEPTH.
- D  input  DATA_WIDTH  data in.
- D_VLD  input  1  qualifier for D.
- Q  output  DATA_WIDTH  data at the selected tap.
- Q_VLD  output  1  valid at the selected tap.
- PERR  output  1  sticky parity error; present only with DSP_PIPE_PARITY_EN, otherwise tied to 0.
- PINJ  input  1  parity-inject test input; present only with DSP_PIPE_PARITY_EN.

## Operation
- The chain is stage[0..DEPTH-1]. Each stage holds {vld, data} and, with the macro, a parity bit.
- On a rising edge with CE=1 and SRST=0: stage[0] <= {D_VLD, D} and stage[i] <= stage[i-1]. The whole chain shifts as one; there are no per-stage bubbles or holds.
- With CE=0, all stages hold, including vld.
- SRST=1 clears every stage's data and vld to 0. SRST has priority over CE.
- RST=1 clears the same state immediately, independent of CLK. RST has priority over SRST.
- Output tap:
  - LAT=0: Q=D and Q_VLD=D_VLD (combinational bypass).
  - LAT=k (1..DEPTH): Q=stage[k-1].data and Q_VLD=stage[k-1].vld.
  - LAT>DEPTH: clamped to DEPTH.
- LAT may change at any time. The tap mux switches combinationally, and stage contents are not altered. The block does not flush on a LAT change; the consumer discards data across the change.
- Data is captured regardless of D_VLD. vld only qualifies it, so Q shows stale data while Q_VLD=0.

## Timing
- Reset values: every stage is 0. With LAT≥1, Q=0, Q_VLD=0 and PERR=0 while RST is high and after it. With LAT=0, Q and Q_VLD follow D and D_VLD even during reset.
- Latency with CE held at 1: a sample presented before edge n appears at Q after edge n+LAT-1, i.e. exactly LAT rising edges from presentation.
- Each CE=0 cycle adds one cycle of latency to every sample in flight.
- Throughput: one sample per CE-qualified edge.
- SRST and CE asserted together: the flush wins, and D is not captured on that edge.
- RST deassertion is synchronised by the consumer; the block has no internal synchroniser.

## Configuration
- Macro DSP_PIPE_PARITY_EN.
- Defined:
  - stage[0] captures parity = ^D XOR PINJ alongside the data, and parity shifts with the data.
  - When LAT≥1, Q_VLD=1 and ^Q ≠ stored parity at the tap, PERR is set on the next rising edge (registered, CE-independent).
  - PERR stays set until RST or SRST.
  - LAT=0 is never checked.
- Undefined: there is no parity storage; PINJ is absent, PERR is constant 0, and the logic is otherwise identical.

## Test plan
- Reset state: RST pulsed mid-stream with LAT=3 → Q=0 and Q_VLD=0 within the same cycle; after release, the first valid output appears 3 edges after the first D_VLD=1.
- Latency sweep: LAT=0..DEPTH (DEPTH=4), D incrementing 0x00001, 0x00002, ... with D_VLD=1 → Q equals D delayed by exactly LAT edges; LAT=0 gives zero delay.
- CE stall: LAT=2, D=0x3FFFF then 0x00005, CE low for 3 cycles between them → Q holds 0x3FFFF across the stall, and 0x00005 emerges 2 CE-qualified edges after capture.
- Flush priority: SRST=1 and CE=1 together with D=0x12345 → next cycle every stage is 0 and Q_VLD=0 for every LAT; 0x12345 never appears.
- Clamp and LAT change: LAT=7 with DEPTH=4 → behaves as LAT=4; switching LAT from 4 to 1 mid-stream → Q jumps to stage[0] on the same cycle with no stage corruption.
- Parity (macro on): PINJ=1 for one sample 0x0000F with LAT=2 → PERR rises on the edge after that sample is at Q with Q_VLD=1, stays 1, and clears on SRST.
